// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU ops, strobe bit indices and FSM states for control_unit (optional macro CU_SINGLE_STEP_EN)
package cpu_pkg;

  localparam int OPW_DEF = 5;
  localparam int RFW_DEF = 4;

  // Opcodes (ir[31:27]); shra has no arithmetic ALU op and is issued as SHR
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_HALT = 5'd27;

  // ALU operation codes on Control_Signals
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;

  // enable[] bit indices
  localparam int PC_IN  = 20;
  localparam int MDR_IN = 21;
  localparam int IR_IN  = 23;
  localparam int Z_IN   = 24;
  localparam int MAR_IN = 25;
  localparam int Y_IN   = 27;
  localparam int INC_PC = 28;

  // busSelect[] bit indices
  localparam int ZLO_OUT = 19;
  localparam int PC_OUT  = 20;
  localparam int MDR_OUT = 21;
  localparam int C_OUT   = 22;

  typedef enum logic [2:0] {
    CLS_LD, CLS_LDI, CLS_ALU, CLS_IMM, CLS_HALT, CLS_ILL
  } op_class_t;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_t;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational IR field extraction and opcode classification
import cpu_pkg::*;

module cu_decoder #(
  parameter int OPW = OPW_DEF,
  parameter int RFW = RFW_DEF
) (
  input  logic [31:0]    ir,
  output op_class_t      op_class,
  output logic [3:0]     alu_op,
  output logic [RFW-1:0] ra,
  output logic [RFW-1:0] rb,
  output logic [RFW-1:0] rc,
  output logic           illegal
);

  logic [OPW-1:0] opcode;
  logic           unused_ir_low;

  assign opcode  = ir[31 -: OPW];
  assign ra      = ir[31-OPW -: RFW];
  assign rb      = ir[31-OPW-RFW -: RFW];
  assign rc      = ir[31-OPW-2*RFW -: RFW];
  // Immediate bits are consumed by the datapath's C operand, not here
  assign unused_ir_low = ^ir[31-OPW-3*RFW:0];
  assign illegal = (op_class == CLS_ILL);

  // Map opcode to instruction class and the ALU op used in T4
  always_comb begin
    op_class = CLS_ILL;
    alu_op   = ALU_NONE;
    case (opcode)
      OP_LD:   begin op_class = CLS_LD;   alu_op = ALU_ADD; end
      OP_LDI:  begin op_class = CLS_LDI;  alu_op = ALU_ADD; end
      OP_ADD:  begin op_class = CLS_ALU;  alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_ALU;  alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU;  alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU;  alu_op = ALU_OR;  end
      OP_ROR:  begin op_class = CLS_ALU;  alu_op = ALU_ROR; end
      OP_ROL:  begin op_class = CLS_ALU;  alu_op = ALU_ROL; end
      OP_SHR:  begin op_class = CLS_ALU;  alu_op = ALU_SHR; end
      OP_SHRA: begin op_class = CLS_ALU;  alu_op = ALU_SHR; end
      OP_SHL:  begin op_class = CLS_ALU;  alu_op = ALU_SHL; end
      OP_ADDI: begin op_class = CLS_IMM;  alu_op = ALU_ADD; end
      OP_ANDI: begin op_class = CLS_IMM;  alu_op = ALU_AND; end
      OP_ORI:  begin op_class = CLS_IMM;  alu_op = ALU_OR;  end
      OP_HALT: begin op_class = CLS_HALT; end
      default: begin op_class = CLS_ILL;  end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore control FSM driving the datapath strobes (optional macro CU_SINGLE_STEP_EN adds step/WAIT)
import cpu_pkg::*;

module control_unit #(
  parameter int OPW = OPW_DEF,
  parameter int RFW = RFW_DEF
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        MD_Read,
  output logic        IncPC,
  output logic [3:0]  Control_Signals,
  output logic        run,
  output logic        illegal
);

  state_t         state;
  state_t         next_state;
  state_t         done_state;
  op_class_t      op_class;
  logic [3:0]     alu_op;
  logic [RFW-1:0] ra;
  logic [RFW-1:0] rb;
  logic [RFW-1:0] rc;
  logic           dec_illegal;

  cu_decoder #(.OPW(OPW), .RFW(RFW)) u_dec (
    .ir       (ir),
    .op_class (op_class),
    .alu_op   (alu_op),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .illegal  (dec_illegal)
  );

`ifdef CU_SINGLE_STEP_EN
  assign done_state = S_WAIT;
`else
  assign done_state = S_T0;
`endif

  assign IncPC = enable[INC_PC];

  // State register and sticky illegal-opcode flag; clr overrides everything
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_RST;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_T3 && dec_illegal) illegal <= 1'b1;
    end
  end

  // Next state and per-T-state strobes; everything defaults to idle
  always_comb begin
    next_state      = state;
    enable          = '0;
    busSelect       = '0;
    MD_Read         = 1'b0;
    Control_Signals = ALU_NONE;
    run             = 1'b1;
    case (state)
      S_RST: begin
        run        = 1'b0;
        next_state = S_T0;
      end
      S_T0: begin
        busSelect[PC_OUT] = 1'b1;
        enable[MAR_IN]    = 1'b1;
        enable[Z_IN]      = 1'b1;
        enable[INC_PC]    = 1'b1;
        next_state        = S_T1;
      end
      S_T1: begin
        busSelect[ZLO_OUT] = 1'b1;
        enable[PC_IN]      = 1'b1;
        MD_Read            = 1'b1;
        enable[MDR_IN]     = 1'b1;
        next_state         = S_T2;
      end
      S_T2: begin
        busSelect[MDR_OUT] = 1'b1;
        enable[IR_IN]      = 1'b1;
        next_state         = S_T3;
      end
      S_T3: begin
        if (op_class == CLS_HALT || op_class == CLS_ILL) begin
          next_state = S_HALT;
        end else begin
          busSelect[rb] = 1'b1;
          enable[Y_IN]  = 1'b1;
          next_state    = S_T4;
        end
      end
      S_T4: begin
        if (op_class == CLS_ALU) busSelect[rc]    = 1'b1;
        else                     busSelect[C_OUT] = 1'b1;
        Control_Signals = alu_op;
        enable[Z_IN]    = 1'b1;
        next_state      = S_T5;
      end
      S_T5: begin
        busSelect[ZLO_OUT] = 1'b1;
        if (op_class == CLS_LD) begin
          enable[MAR_IN] = 1'b1;
          next_state     = S_T6;
        end else begin
          enable[ra] = 1'b1;
          next_state = done_state;
        end
      end
      S_T6: begin
        MD_Read        = 1'b1;
        enable[MDR_IN] = 1'b1;
        next_state     = S_T7;
      end
      S_T7: begin
        busSelect[MDR_OUT] = 1'b1;
        enable[ra]         = 1'b1;
        next_state         = done_state;
      end
      S_HALT: begin
        run = 1'b0;
      end
`ifdef CU_SINGLE_STEP_EN
      S_WAIT: begin
        run = 1'b0;
        if (step) next_state = S_T0;
      end
`endif
      default: begin
        run        = 1'b0;
        next_state = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench: control_unit driving a behavioural datapath, checked against an instruction-level model
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic        MD_Read;
  logic        IncPC;
  logic [3:0]  Control_Signals;
  logic        run;
  logic        illegal;
`ifdef CU_SINGLE_STEP_EN
  logic        step = 1'b1;
  localparam int WAIT_CYC = 1;
`else
  localparam int WAIT_CYC = 0;
`endif

  localparam logic [31:0] T0_EN  = 32'h1300_0000;
  localparam logic [31:0] T0_BUS = 32'h0010_0000;
  localparam logic [31:0] HALT_I = 32'hD800_0000;

  always #5 clk = ~clk;

  control_unit dut (
    .clk             (clk),
    .clr             (clr),
`ifdef CU_SINGLE_STEP_EN
    .step            (step),
`endif
    .ir              (ir),
    .enable          (enable),
    .busSelect       (busSelect),
    .MD_Read         (MD_Read),
    .IncPC           (IncPC),
    .Control_Signals (Control_Signals),
    .run             (run),
    .illegal         (illegal)
  );

  // Behavioural datapath: memory, register file and the special registers
  logic [31:0] mem    [0:255];
  logic [31:0] r_init [0:15];
  logic [31:0] R      [0:15];
  logic [31:0] pc, mar, mdr, ir_q, y, z, bus;

  assign ir = ir_q;

  function automatic logic [31:0] sext19(input logic [18:0] c);
    return {{13{c[18]}}, c};
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a >> b[4:0];
      4'd6: return a << b[4:0];
      4'd7: return (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      4'd8: return (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (busSelect[i]) bus = bus | R[i];
    if (busSelect[19]) bus = bus | z;
    if (busSelect[20]) bus = bus | pc;
    if (busSelect[21]) bus = bus | mdr;
    if (busSelect[22]) bus = bus | sext19(ir_q[18:0]);
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) R[i] <= r_init[i];
      pc <= '0; mar <= '0; mdr <= '0; ir_q <= '0; y <= '0; z <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (enable[i]) R[i] <= bus;
      if (enable[20]) pc <= bus;
      if (enable[25]) mar <= bus;
      if (enable[21]) mdr <= MD_Read ? mem[mar[7:0]] : bus;
      if (enable[23]) ir_q <= bus;
      if (enable[27]) y <= bus;
      if (enable[24]) z <= IncPC ? bus + 32'd1 : alu(Control_Signals, y, bus);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("bus_onehot", 32'($countones(busSelect) <= 1), 32'd1);
  endtask

  task automatic wait_t0(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(enable == T0_EN && busSelect == T0_BUS) && cyc < 60);
    if (!(enable == T0_EN && busSelect == T0_BUS)) begin
      check("t0_reached_en", enable, T0_EN);
      check("t0_reached_bus", busSelect, T0_BUS);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) r_init[i] = 32'h0;
  endtask

  // Instruction-level reference model
  logic [31:0] iss [0:15];

  task automatic iss_step(input logic [31:0] inst, output int len, output int ra_o);
    logic [4:0]  op;
    logic [31:0] a, b, c, addr, res;
    logic [63:0] dbl;
    op   = inst[31:27];
    ra_o = int'(inst[26:23]);
    a    = iss[inst[22:19]];
    b    = iss[inst[18:15]];
    c    = sext19(inst[18:0]);
    len  = 6;
    res  = 32'h0;
    case (op)
      5'd0:  begin addr = a + c; res = mem[addr[7:0]]; len = 8; end
      5'd1:  res = a + c;
      5'd3:  res = a + b;
      5'd4:  res = a - b;
      5'd5:  res = a & b;
      5'd6:  res = a | b;
      5'd7:  begin dbl = {a, a} >> b[4:0]; res = dbl[31:0]; end
      5'd8:  begin dbl = {a, a} << b[4:0]; res = dbl[63:32]; end
      5'd9:  res = a >> b[4:0];
      5'd10: res = a >> b[4:0];
      5'd11: res = a << b[4:0];
      5'd12: res = a + c;
      5'd13: res = a & c;
      5'd14: res = a | c;
      default: res = iss[ra_o];
    endcase
    iss[ra_o] = res;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int cyc, len, ra_i, cnt;
  int unsigned legal_ops [14] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
  logic [4:0] op_r;

  initial begin
    // AND, back-to-back ADDs, then clr held mid-T4
    clear_prog();
    r_init[2] = 32'd5;
    r_init[3] = 32'd6;
    mem[0] = 32'h2891_8000;
    mem[1] = {5'd3, 4'd4, 4'd1, 4'd3, 15'd0};
    mem[2] = {5'd3, 4'd5, 4'd4, 4'd4, 15'd0};
    mem[3] = HALT_I;
    do_reset();
    check("rst_run", {31'd0, run}, 32'd0);
    wait_t0(cyc);
    check("rel_cycles", cyc, 1);
    check("rel_bus", busSelect, T0_BUS);
    check("rel_en", enable, T0_EN);
    check("pc_i0", pc, 0);
    repeat (4) tick();
    check("and_t4_cs", Control_Signals, 32'd3);
    check("and_t4_bus", busSelect, 32'h0000_0008);
    check("and_t4_en", enable, 32'h0100_0000);
    wait_t0(cyc);
    check("and_len", cyc, 2 + WAIT_CYC);
    check("and_r1", R[1], 32'd4);
    check("pc_i1", pc, 1);
    repeat (4) tick();
    check("add_t4_cs", Control_Signals, 32'd1);
    check("add_t4_bus", busSelect, 32'h0000_0008);
    wait_t0(cyc);
    check("add_len", cyc, 2 + WAIT_CYC);
    check("add_r4", R[4], 32'd10);
    check("pc_i2", pc, 2);
    repeat (4) tick();
    check("add2_t4_cs", Control_Signals, 32'd1);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("clr_en", enable, 32'h0);
      check("clr_bus", busSelect, 32'h0);
      check("clr_misc", {25'd0, Control_Signals, MD_Read, IncPC, run}, 32'h0);
      check("clr_ill", {31'd0, illegal}, 32'd0);
    end
    clr = 1'b0;
    tick();
    check("clr_rel_bus", busSelect, T0_BUS);
    check("clr_rel_en", enable, T0_EN);
    check("clr_rel_run", {31'd0, run}, 32'd1);

    // ld R1, 4(R2)
    clear_prog();
    r_init[2] = 32'h10;
    mem[0]    = {5'd0, 4'd1, 4'd2, 19'd4};
    mem[1]    = HALT_I;
    mem[8'h14] = 32'h0000_ABCD;
    do_reset();
    wait_t0(cyc);
    check("ld_first", cyc, 1);
    repeat (3) tick();
    check("ld_t3_bus", busSelect, 32'h0000_0004);
    check("ld_t3_en", enable, 32'h0800_0000);
    tick();
    check("ld_t4_bus", busSelect, 32'h0040_0000);
    check("ld_t4_cs", Control_Signals, 32'd1);
    tick();
    check("ld_t5_bus", busSelect, 32'h0008_0000);
    check("ld_t5_en", enable, 32'h0200_0000);
    tick();
    check("ld_mar", mar, 32'h14);
    check("ld_t6_md", {31'd0, MD_Read}, 32'd1);
    check("ld_t6_en", enable, 32'h0020_0000);
    wait_t0(cyc);
    check("ld_len", cyc, 2 + WAIT_CYC);
    check("ld_r1", R[1], 32'h0000_ABCD);

    // Illegal opcode 31
    clear_prog();
    mem[0] = 32'hF800_0000;
    do_reset();
    wait_t0(cyc);
    repeat (3) tick();
    check("ill_t3_flag", {31'd0, illegal}, 32'd0);
    check("ill_t3_run", {31'd0, run}, 32'd1);
    tick();
    check("ill_flag", {31'd0, illegal}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      check("ill_quiet", {25'd0, Control_Signals, MD_Read, IncPC, run}, 32'h0);
      check("ill_quiet_strobes", enable | busSelect, 32'h0);
      tick();
    end
    check("ill_sticky", {31'd0, illegal}, 32'd1);
    clr = 1'b1;
    tick();
    check("ill_cleared", {31'd0, illegal}, 32'd0);
    clr = 1'b0;

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) r_init[i] = $urandom;
    for (int k = 0; k < 40; k++) begin
      op_r   = 5'(legal_ops[$urandom_range(0, 13)]);
      mem[k] = {op_r, 27'($urandom)};
    end
    mem[40] = HALT_I;
    for (int i = 0; i < 16; i++) iss[i] = r_init[i];
    do_reset();
    wait_t0(cyc);
    check("rnd_first", cyc, 1);
    for (int k = 0; k < 40; k++) begin
      check("rnd_pc", pc, k);
      iss_step(mem[k], len, ra_i);
      wait_t0(cyc);
      check("rnd_len", cyc, len + WAIT_CYC);
      check("rnd_reg", R[ra_i], iss[ra_i]);
    end
    check("rnd_pc_halt", pc, 40);
    repeat (4) tick();
    check("rnd_halt_run", {31'd0, run}, 32'd0);
    check("rnd_halt_ill", {31'd0, illegal}, 32'd0);
    check("rnd_halt_en", enable, 32'h0);

`ifdef CU_SINGLE_STEP_EN
    // Single-step: WAIT holds while step is low, one pulse runs one instruction
    clear_prog();
    r_init[2] = 32'd5;
    r_init[3] = 32'd6;
    mem[0] = 32'h2891_8000;
    mem[1] = {5'd3, 4'd4, 4'd1, 4'd3, 15'd0};
    mem[2] = HALT_I;
    step = 1'b0;
    do_reset();
    wait_t0(cyc);
    repeat (6) tick();
    for (int k = 0; k < 10; k++) begin
      check("ss_wait_run", {31'd0, run}, 32'd0);
      check("ss_wait_en", enable, 32'h0);
      tick();
    end
    check("ss_r1", R[1], 32'd4);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_t0_en", enable, T0_EN);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (run && cnt < 20);
    check("ss_len", cnt, 6);
    check("ss_r4", R[4], 32'd10);
    repeat (5) tick();
    check("ss_hold_run", {31'd0, run}, 32'd0);
    check("ss_hold_pc", pc, 2);
    step = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control FSM directly upstream of `datapath`; drives its `enable`, `busSelect`, `MD_Read`, `IncPC` and `Control_Signals` inputs, replacing hand-driven bench stimulus.
- Sequences fetch (T0-T2), decode, and execute (T3-T7) for register-register ALU, immediate ALU, `ld`, `ldi` and `halt`, one T-state per clock.
- Decodes the IR contents fed back from the datapath.

Parameters:
- `OPW`, 5, opcode field width; field is `ir[31:27]`.
- `RFW`, 4, register field width: Ra=`ir[26:23]`, Rb=`ir[22:19]`, Rc=`ir[18:15]`.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous active-high reset.
- `ir`  in  32  IR register value from datapath.
- `enable`  out  32  register load strobes: [15:0] R0-R15 in, [18] HI, [19] LO, [20] PC, [21] MDR, [23] IR, [24] Z, [25] MAR, [27] Y, [28] IncPC.
- `busSelect`  out  32  bus source, one-hot or zero: [15:0] R out, [16] HI, [17] LO, [18] Zhi, [19] Zlo, [20] PC, [21] MDR, [22] C (sign-extended `ir[18:0]`).
- `MD_Read`  out  1  MDR takes memory data instead of bus.
- `IncPC`  out  1  mirrors `enable[28]`.
- `Control_Signals`  out  4  ALU op: ADD=1, SUB=2, AND=3, OR=4, SHR=5, SHL=6, ROR=7, ROL=8.
- `run`  out  1  high except in RST and HALT.
- `illegal`  out  1  sticky, set on unknown opcode.

Behaviour:
- One clock; reset synchronous active-high on `clr` (decided).
- `clr` at any edge, including mid-instruction: next state RST and `illegal`=0.
- In RST: all outputs 0, including `run`. The first edge with `clr` low moves to T0.
- Moore outputs: combinational from registered state and `ir` only; `busSelect` has at most one bit set.
- Outputs are 0 in any state that does not set them.
- T0: busSelect[20], enable[25], enable[24], IncPC/enable[28].
- T1: busSelect[19], enable[20], MD_Read, enable[21].
- T2: busSelect[21], enable[23].
- T3 onward: decode uses `ir`, already valid because IR was loaded at the T2 edge.
- Reg-reg ALU, opcodes 3-11:
  - T3: Rb out, Y in.
  - T4: Rc out, `Control_Signals`=op, Z in.
  - T5: Zlo out, Ra in.
  - Then T0. Total 6 cycles.
- Immediate addi/andi/ori (12-14): as reg-reg but T4 drives busSelect[22] instead of Rc.
- ldi (1):
  - T3: Rb out, Y in.
  - T4: C out, ADD, Z in.
  - T5: Zlo out, Ra in.
- ld (0):
  - T3-T4: as ldi.
  - T5: Zlo out, MAR in.
  - T6: MD_Read, MDR in.
  - T7: MDR out, Ra in.
  - Then T0. Total 8 cycles.
- Register out-select uses Rb/Rc/Ra field value as the bit index.
- `Control_Signals` is held only in T4; 0 elsewhere.
- halt (27): T3 to HALT; HALT holds with all strobes 0 until `clr`.
- Any other opcode: T3 to HALT and set `illegal`.
- State encoding (4 bits): RST, T0-T7, HALT.

Optional Feature:
- Macro `CU_SINGLE_STEP_EN`.
- Defined: adds input port `step` (1 bit). At the end of T5/T7 (instruction completion) the FSM enters WAIT (all outputs 0, `run`=0) and proceeds to T0 on the edge where `step`=1. A `step` already high on entry to WAIT advances on the next edge.
- Undefined: no `step` port, no WAIT state; completion goes straight to T0.

Decomposition:
- Package `cpu_pkg`:
  - opcode constants;
  - ALU op constants;
  - `enable`/`busSelect` bit-index constants (PC_IN=20, MDR_IN=21, IR_IN=23, Z_IN=24, MAR_IN=25, Y_IN=27, INC_PC=28, ZLO_OUT=19, PC_OUT=20, MDR_OUT=21, C_OUT=22);
  - state enum.
- Sub-module `cu_decoder`: pure combinational `ir` to {opcode class, alu_op, ra, rb, rc, illegal}.
- FSM and output logic stay in `control_unit`.

Test Plan:
- Reset: hold `clr` 3 cycles mid-T4 → all outputs 0, `run`=0. First edge after release → state T0, `busSelect`=0x00100000, `enable`=0x13000000.
- AND: datapath connected, R2=5, R3=6, memory returns 0x28918000 → after 6 cycles R1=4. In T4, `Control_Signals`=3 and `busSelect`=0x00000008.
- Back-to-back: two ADD instructions → PC increments by 1 each T0, no idle cycle between T5 and T0.
- ld: Rb=R2=0x10, C=4, mem[0x14]=0xABCD → R1=0xABCD after 8 cycles. MAR loaded with 0x14 in T5.
- Illegal: opcode 31 → HALT at the edge after T3, `illegal`=1, `run`=0, outputs stay 0 for 20 cycles. `clr` clears `illegal`.
- `CU_SINGLE_STEP_EN`: `step` held low → FSM stays in WAIT. A single-cycle `step` pulse → exactly one instruction executes, then returns to WAIT.
